// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-memory req/ack bus between the fetch stage and imem
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - DLX instruction-fetch stage with skid buffer, jump delay slot and branch squash
// The in-flight fetch is either on-path (FETCH) or known stale (DROP); stale data is consumed and discarded.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                    IFclk,
    input  logic                    IFrst,
    input  logic                    IFhold,
    input  logic                    jflag,
    input  logic [31:0]             jumpPC,
    input  logic                    brtaken,
    input  logic [31:0]             brPC,
    if_fetch_stage_if.master        imem,
    output logic [31:0]             instr,
    output logic [31:0]             PCplus4,
    output logic [31:0]             PCplus8,
    output logic                    IFvalid
);

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] tgt_q;
    logic        skid_full_q;
    logic [31:0] skid_word_q;
    logic [31:0] skid_addr_q;
    logic        jpend_q;
    logic [31:0] instr_q;
    logic [31:0] pcp4_q;
    logic [31:0] pcp8_q;
    logic        valid_q;

    logic        req;
    logic        ack;
    logic        fetch_ack;
    logic        src_vld;
    logic [31:0] src_word;
    logic [31:0] src_addr;
    logic        redir;
    logic [31:0] redir_tgt;

    assign req       = IFrst & ~skid_full_q;
    assign ack       = req & imem.imem_ack;
    assign fetch_ack = ack & (state_q == FETCH);

    // A buffered word always goes out before anything newly acknowledged.
    assign src_vld   = skid_full_q | fetch_ack;
    assign src_word  = skid_full_q ? skid_word_q : imem.imem_rdata;
    assign src_addr  = skid_full_q ? skid_addr_q : addr_q;

    // A pending jump fires when its delay slot is delivered; otherwise a J/JAL redirects on delivery.
    assign redir     = src_vld & (jpend_q | jflag);
    assign redir_tgt = jpend_q ? tgt_q : jumpPC;

    always_ff @(posedge IFclk or negedge IFrst) begin
        if (!IFrst) begin
            state_q     <= FETCH;
            addr_q      <= RESET_PC;
            tgt_q       <= RESET_PC;
            skid_full_q <= 1'b0;
            skid_word_q <= NOP_INSTR;
            skid_addr_q <= RESET_PC;
            jpend_q     <= 1'b0;
            instr_q     <= NOP_INSTR;
            pcp4_q      <= 32'h0;
            pcp8_q      <= 32'h0;
            valid_q     <= 1'b0;
        end else if (brtaken) begin
            instr_q     <= NOP_INSTR;
            valid_q     <= 1'b0;
            skid_full_q <= 1'b0;
            jpend_q     <= 1'b0;
            if (ack || !req) begin
                addr_q  <= brPC;
                state_q <= FETCH;
            end else begin
                tgt_q   <= brPC;
                state_q <= DROP;
            end
        end else begin
            if (ack && state_q == DROP) begin
                addr_q  <= tgt_q;
                state_q <= FETCH;
            end
            if (IFhold) begin
                if (fetch_ack && !skid_full_q) begin
                    skid_full_q <= 1'b1;
                    skid_word_q <= imem.imem_rdata;
                    skid_addr_q <= addr_q;
                    addr_q      <= addr_q + 32'd4;
                end
            end else begin
                if (src_vld) begin
                    instr_q     <= src_word;
                    pcp4_q      <= src_addr + 32'd4;
                    pcp8_q      <= src_addr + 32'd8;
                    valid_q     <= 1'b1;
                    skid_full_q <= 1'b0;
                end else begin
                    instr_q     <= NOP_INSTR;
                    valid_q     <= 1'b0;
                end
                if (fetch_ack) begin
                    addr_q <= addr_q + 32'd4;
                end
                // Redirect overrides the sequential increment; a still-pending fetch becomes stale.
                if (redir) begin
                    jpend_q <= 1'b0;
                    if (ack || !req) begin
                        addr_q  <= redir_tgt;
                        state_q <= FETCH;
                    end else begin
                        tgt_q   <= redir_tgt;
                        state_q <= DROP;
                    end
                end else if (jflag && !src_vld) begin
                    jpend_q <= 1'b1;
                    tgt_q   <= jumpPC;
                end
            end
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = addr_q;
    assign instr          = instr_q;
    assign PCplus4        = pcp4_q;
    assign PCplus8        = pcp8_q;
    assign IFvalid        = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for if_fetch_stage with random latency, holds, jumps and branches
module tb_if_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        hold    = 1'b0;
    logic        jflag   = 1'b0;
    logic [31:0] jumpPC  = 32'h0;
    logic        brtaken = 1'b0;
    logic [31:0] brPC    = 32'h0;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic [31:0] pcp8;
    logic        ifvalid;

    if_fetch_stage_if bus ();

    if_fetch_stage #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (32'h0)
    ) dut (
        .IFclk   (clk),
        .IFrst   (rst_n),
        .IFhold  (hold),
        .jflag   (jflag),
        .jumpPC  (jumpPC),
        .brtaken (brtaken),
        .brPC    (brPC),
        .imem    (bus.master),
        .instr   (instr),
        .PCplus4 (pcp4),
        .PCplus8 (pcp8),
        .IFvalid (ifvalid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int deliveries = 0;

    int          min_lat = 0;
    int          max_lat = 0;
    logic        rand_en = 1'b0;
    logic        force_hold = 1'b0;
    logic        force_br = 1'b0;
    logic [31:0] force_brpc = 32'h0;

    // Program image: one J per 32 words (never in a delay slot), everything else a plain ALU word.
    function automatic logic is_jloc(input logic [31:0] a);
        return a[6:2] == 5'd9;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        h = (a * 32'h9E37_79B1) ^ 32'h1234_5678;
        return is_jloc(a) ? {6'h02, h[25:0]} : {6'h08, h[25:0]};
    endfunction

    function automatic logic is_j(input logic [31:0] w);
        return w[31:26] == 6'h02;
    endfunction

    function automatic logic [31:0] jtarget(input logic [31:0] w);
        return {4'h0, w[25:0], 2'b00};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_true(input string name, input logic cond, input int info);
        checks++;
        if (!cond) begin
            errors++;
            $display("FAIL %s: condition false (value %0d)", name, info);
        end
    endtask

    // Instruction memory: random latency per transaction, data only valid with ack.
    int   wcnt = 0;
    int   lat = 0;
    logic prev_req = 1'b0;
    logic prev_ack = 1'b0;
    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wcnt = 0;
                lat  = $urandom_range(max_lat, min_lat);
            end else if (prev_req && prev_ack) begin
                wcnt = 0;
                lat  = $urandom_range(max_lat, min_lat);
            end else if (prev_req) begin
                wcnt++;
            end
            bus.imem_ack   = (wcnt >= lat);
            bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;
            prev_req = bus.imem_req;
            prev_ack = bus.imem_ack;
        end
    end

    // ID / EX / hazard-unit stand-in.
    initial begin
        forever begin
            @(negedge clk);
            jflag  = ifvalid && is_j(instr);
            jumpPC = jtarget(instr);
            hold   = force_hold || (rand_en && ($urandom_range(0, 3) == 0));
            if (force_br) begin
                brtaken = 1'b1;
                brPC    = force_brpc;
            end else if (rand_en && ($urandom_range(0, 29) == 0)) begin
                brtaken = 1'b1;
                brPC    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'h0FFF_FFFC);
            end else begin
                brtaken = 1'b0;
            end
        end
    end

    // Reference model: program-order address stream with one delay slot per jump.
    logic [31:0] exp_q[$];
    logic        mpend = 1'b0;
    logic [31:0] mtgt = 32'h0;
    logic        adv_s = 1'b0;

    initial begin
        exp_q.push_back(RST_PC);
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_q.delete();
                exp_q.push_back(RST_PC);
                mpend = 1'b0;
                adv_s = 1'b0;
            end else if (brtaken) begin
                exp_q.delete();
                exp_q.push_back(brPC);
                mpend = 1'b0;
                adv_s = 1'b0;
            end else begin
                adv_s = !hold;
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (adv_s && ifvalid) begin
                if (exp_q.size() == 0) begin
                    check_true("deliver_expected", 1'b0, deliveries);
                end else begin
                    a = exp_q.pop_front();
                    w = mem_word(a);
                    check32("deliver_instr", instr, w);
                    check32("deliver_pcplus4", pcp4, a + 32'd4);
                    check32("deliver_pcplus8", pcp8, a + 32'd8);
                    deliveries++;
                    if (mpend) begin
                        exp_q.push_back(mtgt);
                        mpend = 1'b0;
                    end else begin
                        exp_q.push_back(a + 32'd4);
                    end
                    if (is_j(w)) begin
                        mpend = 1'b1;
                        mtgt  = jtarget(w);
                    end
                end
            end
        end
    end

    initial begin
        int d0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check32("rst_instr", instr, 32'h0);
        check32("rst_pcplus4", pcp4, 32'h0);
        check32("rst_pcplus8", pcp8, 32'h0);
        check32("rst_ifvalid", {31'h0, ifvalid}, 32'h0);
        check32("rst_imem_req", {31'h0, bus.imem_req}, 32'h0);
        check32("rst_imem_addr", bus.imem_addr, RST_PC);

        // Zero-latency fetch: first beat visible in the second cycle after release.
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk); #1;
        check32("first_cycle_req", {31'h0, bus.imem_req}, 32'h1);
        check32("first_cycle_valid", {31'h0, ifvalid}, 32'h0);
        @(negedge clk); #1;
        check32("second_cycle_valid", {31'h0, ifvalid}, 32'h1);
        check32("second_cycle_pcplus4", pcp4, 32'h104);
        check32("second_cycle_pcplus8", pcp8, 32'h108);
        repeat (2) @(negedge clk);

        // Hold with ack every cycle: skid fills once and the request drops.
        #1 force_hold = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check32("hold_req_low", {31'h0, bus.imem_req}, 32'h0);
        check32("hold_valid", {31'h0, ifvalid}, 32'h1);
        force_hold = 1'b0;
        repeat (10) @(negedge clk);

        // Random latency, holds, jumps and branches.
        d0 = deliveries;
        max_lat = 3;
        rand_en = 1'b1;
        repeat (3000) @(negedge clk);
        #1 rand_en = 1'b0;
        check_true("random_progress", deliveries > d0 + 300, deliveries - d0);

        // Branch while a 3-cycle fetch is outstanding: stale word dropped, 0x800 comes first.
        min_lat = 3;
        max_lat = 3;
        repeat (10) @(negedge clk);
        #1 force_br = 1'b1;
        force_brpc = 32'h0000_0800;
        @(negedge clk); #1 force_br = 1'b0;
        @(negedge clk); #1;
        check32("br_squash_valid", {31'h0, ifvalid}, 32'h0);
        d0 = deliveries;
        repeat (20) @(negedge clk);
        check_true("br_progress", deliveries > d0, deliveries - d0);

        // Address wrap past 0xFFFF_FFFC.
        min_lat = 0;
        max_lat = 0;
        #1 force_br = 1'b1;
        force_brpc = 32'hFFFF_FFF8;
        @(negedge clk); #1 force_br = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check_true("wrap_reached_low", ifvalid && (pcp4 < 32'h0000_0020), int'(pcp4));

        // Reset in the middle of a long wait.
        min_lat = 10;
        max_lat = 10;
        repeat (5) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check32("midrst_req", {31'h0, bus.imem_req}, 32'h0);
        check32("midrst_valid", {31'h0, ifvalid}, 32'h0);
        check32("midrst_addr", bus.imem_addr, RST_PC);
        min_lat = 0;
        max_lat = 2;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        d0 = deliveries;
        repeat (30) @(negedge clk);
        check_true("after_reset_progress", deliveries > d0 + 5, deliveries - d0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
